// File: rtl/wb_queue_pkg.sv
// Shared defaults and entry type for the writeback queue.
// Used by wb_queue and, when WB_QUEUE_BYPASS_EN is defined, wbq_lookup.
package wb_queue_pkg;

   localparam int WBQ_DEPTH_DEF  = 4;
   localparam int WBQ_DATA_W_DEF = 64;
   localparam int WBQ_ADDR_W_DEF = 5;

   typedef struct packed {
      logic [WBQ_ADDR_W_DEF-1:0] addr;
      logic [WBQ_DATA_W_DEF-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/wbq_lookup.sv
// Youngest-match search over the occupied queue entries (one bypass read port).
// Only compiled when WB_QUEUE_BYPASS_EN is defined.
`ifdef WB_QUEUE_BYPASS_EN
module wbq_lookup
   import wb_queue_pkg::*;
#(
   parameter int DEPTH  = WBQ_DEPTH_DEF,
   parameter int DATA_W = WBQ_DATA_W_DEF,
   parameter int ADDR_W = WBQ_ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0]        i_addrs [DEPTH],
   input  logic [DATA_W-1:0]        i_datas [DEPTH],
   input  logic [$clog2(DEPTH)-1:0] i_head,
   input  logic [$clog2(DEPTH):0]   i_count,
   input  logic [ADDR_W-1:0]        i_key,
   output logic                     o_hit,
   output logic [DATA_W-1:0]        o_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Walk oldest to youngest so the last match found wins.
   always_comb begin
      logic [PW-1:0] v_idx;
      o_hit  = 1'b0;
      o_data = '0;
      v_idx  = i_head;
      for (int k = 0; k < DEPTH; k++) begin
         v_idx = i_head + PW'(k);
         if ((CW'(k) < i_count) && (i_key != '0) && (i_addrs[v_idx] == i_key)) begin
            o_hit  = 1'b1;
            o_data = i_datas[v_idx];
         end
      end
   end

endmodule
`endif

// File: rtl/wb_queue.sv
// Writeback queue: circular FIFO draining into the register-file write port.
// Define WB_QUEUE_BYPASS_EN to compile in the two bypass lookup ports.
module wb_queue
   import wb_queue_pkg::*;
#(
   parameter int DEPTH  = WBQ_DEPTH_DEF,
   parameter int DATA_W = WBQ_DATA_W_DEF,
   parameter int ADDR_W = WBQ_ADDR_W_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     rf_hold,
   output logic                     rf_write,
   output logic [ADDR_W-1:0]        rf_addr,
   output logic [DATA_W-1:0]        rf_data,
   input  logic [ADDR_W-1:0]        lk1_addr,
   input  logic [ADDR_W-1:0]        lk2_addr,
   output logic                     lk1_hit,
   output logic                     lk2_hit,
   output logic [DATA_W-1:0]        lk1_data,
   output logic [DATA_W-1:0]        lk2_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_count;

   logic w_ready;
   logic w_write;
   logic w_push;

   // No push-through when full, even if the head drains in the same cycle.
   assign w_ready = reset && (r_count < FULL);
   assign w_write = reset && (r_count != '0) && !rf_hold;
   assign w_push  = in_valid && w_ready && (in_addr != '0);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)  r_tail <= r_tail + 1'b1;
         if (w_write) r_head <= r_head + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_write);
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_addr[r_tail] <= in_addr;
         r_data[r_tail] <= in_data;
      end
   end

   assign in_ready = w_ready;
   assign rf_write = w_write;
   assign rf_addr  = reset ? r_addr[r_head] : '0;
   assign rf_data  = reset ? r_data[r_head] : '0;
   assign count    = r_count;

`ifdef WB_QUEUE_BYPASS_EN
   logic              w_lk1_hit;
   logic              w_lk2_hit;
   logic [DATA_W-1:0] w_lk1_data;
   logic [DATA_W-1:0] w_lk2_data;

   wbq_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lk1 (
      .i_addrs (r_addr),
      .i_datas (r_data),
      .i_head  (r_head),
      .i_count (r_count),
      .i_key   (lk1_addr),
      .o_hit   (w_lk1_hit),
      .o_data  (w_lk1_data)
   );

   wbq_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lk2 (
      .i_addrs (r_addr),
      .i_datas (r_data),
      .i_head  (r_head),
      .i_count (r_count),
      .i_key   (lk2_addr),
      .o_hit   (w_lk2_hit),
      .o_data  (w_lk2_data)
   );

   assign lk1_hit  = reset && w_lk1_hit;
   assign lk2_hit  = reset && w_lk2_hit;
   assign lk1_data = reset ? w_lk1_data : '0;
   assign lk2_data = reset ? w_lk2_data : '0;
`else
   logic w_unused_lk;
   assign w_unused_lk = ^{lk1_addr, lk2_addr};

   assign lk1_hit  = 1'b0;
   assign lk2_hit  = 1'b0;
   assign lk1_data = '0;
   assign lk2_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: vector table, directed corner sequences and a random run
// checked against a queue-based reference model (lookup expectations follow WB_QUEUE_BYPASS_EN).
module tb_wb_queue;
   import wb_queue_pkg::*;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
`ifdef WB_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              rf_hold = 1'b0;
   logic              rf_write;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic [ADDR_W-1:0] lk1_addr = '0;
   logic [ADDR_W-1:0] lk2_addr = '0;
   logic              lk1_hit;
   logic              lk2_hit;
   logic [DATA_W-1:0] lk1_data;
   logic [DATA_W-1:0] lk2_data;
   logic [2:0]        count;

   always #5 clock = ~clock;

   wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .rf_hold  (rf_hold),
      .rf_write (rf_write),
      .rf_addr  (rf_addr),
      .rf_data  (rf_data),
      .lk1_addr (lk1_addr),
      .lk2_addr (lk2_addr),
      .lk1_hit  (lk1_hit),
      .lk2_hit  (lk2_hit),
      .lk1_data (lk1_data),
      .lk2_data (lk2_data),
      .count    (count)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pending writebacks, oldest at index 0.
   wbq_entry_t mq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_lookup(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (a != 0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr == a) begin
               hit = 1'b1;
               d   = mq[i].data;
               break;
            end
         end
      end
      if (!BYP || !reset) begin
         hit = 1'b0;
         d   = '0;
      end
   endtask

   task automatic model_check();
      logic              h;
      logic [DATA_W-1:0] d;
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_in_ready", 64'(in_ready), 64'(reset && mq.size() < DEPTH));
      chk("m_rf_write", 64'(rf_write), 64'(reset && mq.size() != 0 && !rf_hold));
      if (!reset) begin
         chk("m_rf_addr_rst", 64'(rf_addr), 64'd0);
         chk("m_rf_data_rst", rf_data, 64'd0);
      end else if (mq.size() != 0) begin
         chk("m_rf_addr", 64'(rf_addr), 64'(mq[0].addr));
         chk("m_rf_data", rf_data, mq[0].data);
      end
      m_lookup(lk1_addr, h, d);
      chk("m_lk1_hit", 64'(lk1_hit), 64'(h));
      chk("m_lk1_data", lk1_data, d);
      m_lookup(lk2_addr, h, d);
      chk("m_lk2_hit", 64'(lk2_hit), 64'(h));
      chk("m_lk2_data", lk2_data, d);
   endtask

   // Called at a negedge: check against the model, then advance it across the posedge.
   task automatic step_body();
      bit pop;
      bit acc;
      model_check();
      pop = reset && mq.size() != 0 && !rf_hold;
      acc = reset && in_valid && mq.size() < DEPTH;
      @(posedge clock);
      if (!reset) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc && in_addr != 0) mq.push_back('{addr: in_addr, data: in_data});
      end
      #1;
   endtask

   task automatic cycle();
      @(negedge clock);
      step_body();
   endtask

   typedef struct {
      bit                vld;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      bit                hold;
      logic [ADDR_W-1:0] lk1;
      logic [ADDR_W-1:0] lk2;
      bit                e_ready;
      bit                e_write;
      int                e_count;
      bit                e_chkrf;
      logic [ADDR_W-1:0] e_rfaddr;
      logic [DATA_W-1:0] e_rfdata;
      bit                e_lk1hit;
      logic [DATA_W-1:0] e_lk1data;
      bit                e_lk2hit;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1'b1, 5'd3, 64'hAA, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 0, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0};
      tbl[1] = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd3, 5'd0, 1'b1, 1'b1, 1, 1'b1, 5'd3, 64'hAA, 1'b1, 64'hAA, 1'b0};
      tbl[2] = '{1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 0, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0};
      tbl[3] = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 0, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0};
      tbl[4] = '{1'b1, 5'd7, 64'h11, 1'b1, 5'd7, 5'd8, 1'b1, 1'b0, 0, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0};
      tbl[5] = '{1'b1, 5'd7, 64'h22, 1'b1, 5'd7, 5'd8, 1'b1, 1'b0, 1, 1'b1, 5'd7, 64'h11, 1'b1, 64'h11, 1'b0};
      tbl[6] = '{1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 5'd8, 1'b1, 1'b0, 2, 1'b1, 5'd7, 64'h11, 1'b1, 64'h22, 1'b0};
      tbl[7] = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd7, 5'd8, 1'b1, 1'b1, 2, 1'b1, 5'd7, 64'h11, 1'b1, 64'h22, 1'b0};
      tbl[8] = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd7, 5'd8, 1'b1, 1'b1, 1, 1'b1, 5'd7, 64'h22, 1'b1, 64'h22, 1'b0};
      tbl[9] = '{1'b0, 5'd0, 64'h0,  1'b0, 5'd7, 5'd8, 1'b1, 1'b0, 0, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0};

      // Reset held low for two checked cycles.
      reset = 1'b0;
      @(posedge clock);
      #1;
      cycle();
      cycle();
      reset = 1'b1;

      // Vector table: single write, addr-0 drop, same-address bypass under hold.
      for (int i = 0; i < 10; i++) begin
         in_valid = tbl[i].vld;
         in_addr  = tbl[i].addr;
         in_data  = tbl[i].data;
         rf_hold  = tbl[i].hold;
         lk1_addr = tbl[i].lk1;
         lk2_addr = tbl[i].lk2;
         @(negedge clock);
         chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].e_ready));
         chk($sformatf("tbl%0d_write", i), 64'(rf_write), 64'(tbl[i].e_write));
         chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_count));
         if (tbl[i].e_chkrf) begin
            chk($sformatf("tbl%0d_rf_addr", i), 64'(rf_addr), 64'(tbl[i].e_rfaddr));
            chk($sformatf("tbl%0d_rf_data", i), rf_data, tbl[i].e_rfdata);
         end
         chk($sformatf("tbl%0d_lk1_hit", i), 64'(lk1_hit), 64'(BYP && tbl[i].e_lk1hit));
         chk($sformatf("tbl%0d_lk1_data", i), lk1_data, BYP ? tbl[i].e_lk1data : 64'h0);
         chk($sformatf("tbl%0d_lk2_hit", i), 64'(lk2_hit), 64'(BYP && tbl[i].e_lk2hit));
         step_body();
      end
      in_valid = 1'b0;

      // Fill under hold, refused fifth push, then four back-to-back writes.
      rf_hold = 1'b1;
      for (int a = 1; a <= 4; a++) begin
         in_valid = 1'b1;
         in_addr  = ADDR_W'(a);
         in_data  = 64'h100 + 64'(a);
         cycle();
      end
      in_addr = 5'd5;
      in_data = 64'h105;
      @(negedge clock);
      chk("full_ready", 64'(in_ready), 64'd0);
      chk("full_count", 64'(count), 64'd4);
      step_body();
      in_valid = 1'b0;
      rf_hold  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk($sformatf("drain%0d_write", i), 64'(rf_write), 64'd1);
         chk($sformatf("drain%0d_addr", i), 64'(rf_addr), 64'(i + 1));
         step_body();
      end
      @(negedge clock);
      chk("drain_empty", 64'(count), 64'd0);
      step_body();

      // Steady push+pop at occupancy 3; pointers wrap, order tracked by the model.
      rf_hold = 1'b1;
      for (int a = 10; a < 13; a++) begin
         in_valid = 1'b1;
         in_addr  = ADDR_W'(a);
         in_data  = 64'h200 + 64'(a);
         cycle();
      end
      rf_hold = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_addr  = ADDR_W'(13 + i);
         in_data  = 64'h300 + 64'(i);
         @(negedge clock);
         chk($sformatf("stream%0d_count", i), 64'(count), 64'd3);
         chk($sformatf("stream%0d_write", i), 64'(rf_write), 64'd1);
         step_body();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) cycle();

      // Reset while three entries are pending.
      rf_hold = 1'b1;
      for (int a = 20; a < 23; a++) begin
         in_valid = 1'b1;
         in_addr  = ADDR_W'(a);
         in_data  = 64'h400 + 64'(a);
         lk1_addr = 5'd20;
         cycle();
      end
      in_valid = 1'b0;
      rf_hold  = 1'b0;
      reset    = 1'b0;
      @(negedge clock);
      chk("rst_mid_write", 64'(rf_write), 64'd0);
      chk("rst_mid_ready", 64'(in_ready), 64'd0);
      chk("rst_mid_lk1", 64'(lk1_hit), 64'd0);
      step_body();
      reset = 1'b1;
      @(negedge clock);
      chk("rst_after_count", 64'(count), 64'd0);
      chk("rst_after_write", 64'(rf_write), 64'd0);
      step_body();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_addr  = ADDR_W'($urandom_range(0, 7));
         in_data  = {$urandom, $urandom};
         rf_hold  = ($urandom_range(0, 3) == 0);
         lk1_addr = ADDR_W'($urandom_range(0, 7));
         lk2_addr = ADDR_W'($urandom_range(0, 7));
         reset    = ($urandom_range(0, 60) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
